// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage: Mem-control bit map, sequencer states and stack-top helper.
package cpu_pkg;

  localparam int MEM_RD         = 0;
  localparam int MEM_WR         = 1;
  localparam int MEM_PUSH       = 2;
  localparam int MEM_POP        = 3;
  localparam int MEM_PUSH_PC    = 4;
  localparam int MEM_POP_PC     = 5;
  localparam int MEM_PUSH_FLAGS = 6;
  localparam int MEM_POP_FLAGS  = 7;

  localparam int DEF_ADDR_W = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PC_LO = 2'd1,
    S_FLG   = 2'd2
  } seq_state_e;

  function automatic int sp_top(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_sp_unit.sv
// Stack pointer register with +1/-1 update and SP+1 peek.
// With STACK_CHECK_EN defined it also traps stack overflow/underflow into a sticky flag.
module sp_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_p1,
  output logic              fault
`ifdef STACK_CHECK_EN
  ,
  output logic              stack_exc
`endif
);

  localparam logic [ADDR_W-1:0] SpTop  = ADDR_W'(sp_top(ADDR_W));
  localparam logic [ADDR_W-1:0] SpOne  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SpZero = ADDR_W'(0);

  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] sp_d;
  logic [ADDR_W-1:0] sp_m1;

  assign sp    = sp_q;
  assign sp_p1 = sp_q + SpOne;
  assign sp_m1 = sp_q - SpOne;

`ifdef STACK_CHECK_EN
  logic exc_q;
  logic exc_d;

  // A push into word 0 or a pop from an empty stack would wrap the pointer.
  always_comb begin
    fault = (dec && (sp_q == SpZero)) || (inc && (sp_q == SpTop));
    exc_d = exc_q | fault;
  end

  // Sticky exception flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end

  assign stack_exc = exc_q;
`else
  assign fault = 1'b0;
`endif

  // Next SP: a trapped access leaves the pointer where it was.
  always_comb begin
    sp_d = sp_q;
    if (fault) begin
      sp_d = sp_q;
    end else if (inc) begin
      sp_d = sp_p1;
    end else if (dec) begin
      sp_d = sp_m1;
    end else begin
      sp_d = sp_q;
    end
  end

  // SP register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= SpTop;
    end else begin
      sp_q <= sp_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data-memory access, stack ops and multi-word PC/flag push/pop sequencing.
// Optional macro STACK_CHECK_EN adds the o_stack_exc port and stack bounds trapping.
module mem_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int WbSize   = 2,
  parameter int MemSize  = 8,
  parameter int flagSize = 4,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MemSize-1:0]  i_Mem,
  input  logic [WbSize-1:0]   i_WB,
  input  logic [31:0]         i_pc,
  input  logic [2:0]          i_Rdst,
  input  logic [15:0]         i_alu,
  input  logic [15:0]         i_read_data1,
  input  logic [flagSize-1:0] i_flag,
  input  logic [15:0]         i_mem_rdata,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [15:0]         o_mem_wdata,
  output logic                o_mem_we,
  output logic                o_stall,
  output logic [WbSize-1:0]   o_WB,
  output logic [2:0]          o_Rdst,
  output logic [15:0]         o_result,
  output logic                o_pc_valid,
  output logic [31:0]         o_pc,
  output logic                o_flag_valid,
  output logic [flagSize-1:0] o_flag
`ifdef STACK_CHECK_EN
  ,
  output logic                o_stack_exc
`endif
);

  seq_state_e          state_q, state_d;
  logic [15:0]         pc_lo_q, pc_lo_d;
  logic [31:0]         pc_q, pc_d;
  logic [flagSize-1:0] flag_q, flag_d;

  logic seq_push_s, seq_pop_s, seq_flags_s, fl_push_s, fl_pop_s;
  logic push_s, pop_s, wr_s, grp_s, ldst_s;
  logic [ADDR_W-1:0] addr_s, sp_s, sp_p1_s;
  logic [15:0]       wdata_s, flag_word_s;
  logic we_req_s, sp_inc_s, sp_dec_s, fault_s, stall_s, pc_valid_s, flag_valid_s;
  logic stack_exc_s;

  assign flag_word_s = {{(16-flagSize){1'b0}}, i_flag};

  sp_unit #(.ADDR_W(ADDR_W)) u_sp (
    .clk   (clk),
    .rst   (rst),
    .inc   (sp_inc_s),
    .dec   (sp_dec_s),
    .sp    (sp_s),
    .sp_p1 (sp_p1_s),
    .fault (fault_s)
`ifdef STACK_CHECK_EN
    ,
    .stack_exc (stack_exc_s)
`endif
  );

`ifndef STACK_CHECK_EN
  assign stack_exc_s = 1'b0;
`endif

  // Op decode: pc/flag ops beat push/pop, which beat plain rd/wr.
  always_comb begin
    grp_s       = i_Mem[MEM_PUSH_PC] | i_Mem[MEM_POP_PC] | i_Mem[MEM_PUSH_FLAGS] | i_Mem[MEM_POP_FLAGS];
    seq_push_s  = i_Mem[MEM_PUSH_PC];
    seq_pop_s   = ~i_Mem[MEM_PUSH_PC] & i_Mem[MEM_POP_PC];
    seq_flags_s = seq_push_s ? i_Mem[MEM_PUSH_FLAGS] : i_Mem[MEM_POP_FLAGS];
    fl_push_s   = ~seq_push_s & ~seq_pop_s & i_Mem[MEM_PUSH_FLAGS];
    fl_pop_s    = ~seq_push_s & ~seq_pop_s & ~i_Mem[MEM_PUSH_FLAGS] & i_Mem[MEM_POP_FLAGS];
    push_s      = ~grp_s & i_Mem[MEM_PUSH];
    pop_s       = ~grp_s & ~i_Mem[MEM_PUSH] & i_Mem[MEM_POP];
    ldst_s      = ~grp_s & ~i_Mem[MEM_PUSH] & ~i_Mem[MEM_POP];
    wr_s        = ldst_s & i_Mem[MEM_WR];
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_lo_q <= 16'h0000;
      pc_q    <= 32'h0000_0000;
      flag_q  <= {flagSize{1'b0}};
    end else begin
      state_q <= state_d;
      pc_lo_q <= pc_lo_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
    end
  end

  // Next state: the state counts steps of a sequence (IDLE=1st word, PC_LO=2nd, FLG=3rd).
  always_comb begin
    state_d = S_IDLE;
    if (seq_push_s || seq_pop_s) begin
      case (state_q)
        S_IDLE:  state_d = S_PC_LO;
        S_PC_LO: state_d = seq_flags_s ? S_FLG : S_IDLE;
        S_FLG:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  // Memory-side outputs. Push order is hi, lo, flags; pop reverses it.
  always_comb begin
    addr_s   = i_alu[ADDR_W-1:0];
    wdata_s  = i_read_data1;
    we_req_s = 1'b0;
    sp_inc_s = 1'b0;
    sp_dec_s = 1'b0;
    stall_s  = (state_d != S_IDLE);
    if (seq_push_s) begin
      addr_s   = sp_s;
      we_req_s = 1'b1;
      sp_dec_s = 1'b1;
      case (state_q)
        S_IDLE:  wdata_s = i_pc[31:16];
        S_PC_LO: wdata_s = i_pc[15:0];
        S_FLG:   wdata_s = flag_word_s;
        default: wdata_s = i_pc[31:16];
      endcase
    end else if (seq_pop_s || fl_pop_s || pop_s) begin
      addr_s   = sp_p1_s;
      sp_inc_s = 1'b1;
    end else if (fl_push_s) begin
      addr_s   = sp_s;
      wdata_s  = flag_word_s;
      we_req_s = 1'b1;
      sp_dec_s = 1'b1;
    end else if (push_s) begin
      addr_s   = sp_s;
      we_req_s = 1'b1;
      sp_dec_s = 1'b1;
    end else begin
      we_req_s = wr_s;
    end
  end

  // Pop capture. Kept apart from the address logic so read data never loops back into it.
  always_comb begin
    pc_lo_d      = pc_lo_q;
    pc_d         = pc_q;
    flag_d       = flag_q;
    pc_valid_s   = 1'b0;
    flag_valid_s = 1'b0;
    if (seq_pop_s) begin
      case (state_q)
        S_IDLE: begin
          if (seq_flags_s) begin
            flag_d = i_mem_rdata[flagSize-1:0];
          end else begin
            pc_lo_d = i_mem_rdata;
          end
        end
        S_PC_LO: begin
          if (seq_flags_s) begin
            pc_lo_d = i_mem_rdata;
          end else begin
            pc_d       = {i_mem_rdata, pc_lo_q};
            pc_valid_s = 1'b1;
          end
        end
        S_FLG: begin
          pc_d         = {i_mem_rdata, pc_lo_q};
          pc_valid_s   = 1'b1;
          flag_valid_s = 1'b1;
        end
        default: pc_lo_d = pc_lo_q;
      endcase
    end else if (fl_pop_s) begin
      flag_d       = i_mem_rdata[flagSize-1:0];
      flag_valid_s = 1'b1;
    end else begin
      pc_lo_d = pc_lo_q;
    end
  end

  assign o_mem_addr   = rst ? {ADDR_W{1'b0}} : addr_s;
  assign o_mem_wdata  = rst ? 16'h0000 : wdata_s;
  assign o_mem_we     = ~rst & we_req_s & ~fault_s;
  assign o_stall      = ~rst & stall_s;
  assign o_WB         = (rst || stall_s) ? {WbSize{1'b0}} : i_WB;
  assign o_Rdst       = rst ? 3'd0 : i_Rdst;
  assign o_result     = rst ? 16'h0000 :
                        ((i_Mem[MEM_RD] | i_Mem[MEM_POP]) ? i_mem_rdata : i_alu);
  assign o_pc_valid   = ~rst & pc_valid_s;
  assign o_pc         = rst ? 32'h0000_0000 : pc_d;
  assign o_flag_valid = ~rst & flag_valid_s;
  assign o_flag       = rst ? {flagSize{1'b0}} : flag_d;
`ifdef STACK_CHECK_EN
  assign o_stack_exc  = ~rst & stack_exc_s;
`endif

endmodule
